clockwise_rotate_kicker: RTL and testbench

- Sequences a clockwise SRS rotation of the active tetromino (0>>1, 1>>2, 2>>3, 3>>0).
- Walks the clockwise wall-kick tests 0..4, offers each candidate pose to the board collision checker through a valid/response handshake, and accepts the first pose that does not collide.
- Sits between the input/game-control FSM and the collision checker.
- Mirrors the existing counter-clockwise kick table for the opposite rotation direction.

---
 rtl/clockwise_rotate_kicker_pkg.sv | 39 +++
 rtl/clockwise_wallkick_data.sv | 74 +++++++
 rtl/clockwise_rotate_kicker.sv | 136 +++++++++++++
 tb/tb_clockwise_rotate_kicker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clockwise_rotate_kicker_pkg.sv
// ============================================================================
// Module   : clockwise_rotate_kicker_pkg
// Brief    : Shared tetromino types and kicker state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clockwise_rotate_kicker_pkg;

    typedef logic [2:0] tetromino_idx_t;

    localparam tetromino_idx_t TETROMINO_I_IDX = 3'd0;
    localparam tetromino_idx_t TETROMINO_O_IDX = 3'd1;
    localparam tetromino_idx_t TETROMINO_T_IDX = 3'd2;
    localparam tetromino_idx_t TETROMINO_J_IDX = 3'd3;
    localparam tetromino_idx_t TETROMINO_L_IDX = 3'd4;
    localparam tetromino_idx_t TETROMINO_S_IDX = 3'd5;
    localparam tetromino_idx_t TETROMINO_Z_IDX = 3'd6;

    localparam logic [2:0] KICK_LAST_STEP = 3'd4;

    typedef enum logic [1:0] {
        KICK_IDLE  = 2'd0,
        KICK_CHECK = 2'd1,
        KICK_DONE  = 2'd2
    } kicker_state_t;

    // Packs a kick offset as {x[2:0], y[2:0]}.
    function automatic logic [5:0] kick_pack(input int x, input int y);
        logic [2:0] px;
        logic [2:0] py;
        px = 3'(x);
        py = 3'(y);
        return {px, py};
    endfunction

endpackage

`default_nettype wire

// File: rtl/clockwise_wallkick_data.sv
// ============================================================================
// Module   : clockwise_wallkick_data
// Brief    : SRS clockwise wall-kick offsets for (rotation, step, piece).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clockwise_wallkick_data
    import clockwise_rotate_kicker_pkg::*;
(
    input  logic [1:0]          rotation,
    input  logic [2:0]          step,
    input  tetromino_idx_t      idx,
    output logic signed [2:0]   add_x,
    output logic signed [2:0]   add_y
);

    logic [5:0] w_kick;

    always_comb begin
        w_kick = '0;
        if (step > KICK_LAST_STEP) begin
            w_kick = 'x;
        end else if (step == 3'd0 || idx == TETROMINO_O_IDX) begin
            w_kick = '0;
        end else if (idx == TETROMINO_I_IDX) begin
            case ({rotation, step})
                {2'd0, 3'd1}: w_kick = kick_pack(-2,  0);
                {2'd0, 3'd2}: w_kick = kick_pack( 1,  0);
                {2'd0, 3'd3}: w_kick = kick_pack(-2, -1);
                {2'd0, 3'd4}: w_kick = kick_pack( 1,  2);
                {2'd1, 3'd1}: w_kick = kick_pack(-1,  0);
                {2'd1, 3'd2}: w_kick = kick_pack( 2,  0);
                {2'd1, 3'd3}: w_kick = kick_pack(-1,  2);
                {2'd1, 3'd4}: w_kick = kick_pack( 2, -1);
                {2'd2, 3'd1}: w_kick = kick_pack( 2,  0);
                {2'd2, 3'd2}: w_kick = kick_pack(-1,  0);
                {2'd2, 3'd3}: w_kick = kick_pack( 2,  1);
                {2'd2, 3'd4}: w_kick = kick_pack(-1, -2);
                {2'd3, 3'd1}: w_kick = kick_pack( 1,  0);
                {2'd3, 3'd2}: w_kick = kick_pack(-2,  0);
                {2'd3, 3'd3}: w_kick = kick_pack( 1, -2);
                {2'd3, 3'd4}: w_kick = kick_pack(-2,  1);
                default:      w_kick = '0;
            endcase
        end else begin
            case ({rotation, step})
                {2'd0, 3'd1}: w_kick = kick_pack(-1,  0);
                {2'd0, 3'd2}: w_kick = kick_pack(-1,  1);
                {2'd0, 3'd3}: w_kick = kick_pack( 0, -2);
                {2'd0, 3'd4}: w_kick = kick_pack(-1, -2);
                {2'd1, 3'd1}: w_kick = kick_pack( 1,  0);
                {2'd1, 3'd2}: w_kick = kick_pack( 1, -1);
                {2'd1, 3'd3}: w_kick = kick_pack( 0,  2);
                {2'd1, 3'd4}: w_kick = kick_pack( 1,  2);
                {2'd2, 3'd1}: w_kick = kick_pack( 1,  0);
                {2'd2, 3'd2}: w_kick = kick_pack( 1,  1);
                {2'd2, 3'd3}: w_kick = kick_pack( 0, -2);
                {2'd2, 3'd4}: w_kick = kick_pack( 1, -2);
                {2'd3, 3'd1}: w_kick = kick_pack(-1,  0);
                {2'd3, 3'd2}: w_kick = kick_pack(-1, -1);
                {2'd3, 3'd3}: w_kick = kick_pack( 0,  2);
                {2'd3, 3'd4}: w_kick = kick_pack(-1,  2);
                default:      w_kick = '0;
            endcase
        end
    end

    assign add_x = $signed(w_kick[5:3]);
    assign add_y = $signed(w_kick[2:0]);

endmodule

`default_nettype wire

// File: rtl/clockwise_rotate_kicker.sv
// ============================================================================
// Module   : clockwise_rotate_kicker
// Brief    : Walks SRS clockwise kick tests against the collision checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clockwise_rotate_kicker
    import clockwise_rotate_kicker_pkg::*;
#(
    parameter int X_W = 5,
    parameter int Y_W = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  tetromino_idx_t        idx,
    input  logic signed [X_W-1:0] cur_x,
    input  logic signed [Y_W-1:0] cur_y,
    input  logic [1:0]            cur_rot,
    output logic                  chk_valid,
    output logic signed [X_W-1:0] chk_x,
    output logic signed [Y_W-1:0] chk_y,
    output logic [1:0]            chk_rot,
    input  logic                  chk_resp,
    input  logic                  chk_collide,
    output logic                  res_valid,
    output logic                  res_ok,
    output logic signed [X_W-1:0] res_x,
    output logic signed [Y_W-1:0] res_y,
    output logic [1:0]            res_rot
);

    kicker_state_t          r_state;
    logic [2:0]             r_step;
    tetromino_idx_t         r_idx;
    logic signed [X_W-1:0]  r_x;
    logic signed [Y_W-1:0]  r_y;
    logic [1:0]             r_rot;

    logic [2:0]             w_next_step;
    logic [2:0]             w_last;
    logic signed [2:0]      w_add_x;
    logic signed [2:0]      w_add_y;

    // The table is addressed one step ahead so the next candidate can be
    // registered in the same cycle a collision is reported.
    assign w_next_step = 3'(r_step + 3'd1);
    assign w_last      = (r_idx == TETROMINO_O_IDX) ? 3'd0 : KICK_LAST_STEP;

    clockwise_wallkick_data u_kick (
        .rotation (r_rot),
        .step     (w_next_step),
        .idx      (r_idx),
        .add_x    (w_add_x),
        .add_y    (w_add_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= KICK_IDLE;
            r_step    <= '0;
            r_idx     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_rot     <= '0;
            req_ready <= 1'b1;
            chk_valid <= 1'b0;
            chk_x     <= '0;
            chk_y     <= '0;
            chk_rot   <= '0;
            res_valid <= 1'b0;
            res_ok    <= 1'b0;
            res_x     <= '0;
            res_y     <= '0;
            res_rot   <= '0;
        end else begin
            res_valid <= 1'b0;
            case (r_state)
                KICK_IDLE: begin
                    if (req_valid) begin
                        r_idx     <= idx;
                        r_x       <= cur_x;
                        r_y       <= cur_y;
                        r_rot     <= cur_rot;
                        r_step    <= '0;
                        chk_valid <= 1'b1;
                        chk_x     <= cur_x;
                        chk_y     <= cur_y;
                        chk_rot   <= 2'(cur_rot + 2'd1);
                        req_ready <= 1'b0;
                        r_state   <= KICK_CHECK;
                    end
                end
                KICK_CHECK: begin
                    if (chk_resp) begin
                        if (!chk_collide) begin
                            res_ok    <= 1'b1;
                            res_x     <= chk_x;
                            res_y     <= chk_y;
                            res_rot   <= chk_rot;
                            res_valid <= 1'b1;
                            chk_valid <= 1'b0;
                            r_state   <= KICK_DONE;
                        end else if (r_step == w_last) begin
                            res_ok    <= 1'b0;
                            res_x     <= r_x;
                            res_y     <= r_y;
                            res_rot   <= r_rot;
                            res_valid <= 1'b1;
                            chk_valid <= 1'b0;
                            r_state   <= KICK_DONE;
                        end else begin
                            r_step <= w_next_step;
                            chk_x  <= r_x + X_W'(w_add_x);
                            chk_y  <= r_y + Y_W'(w_add_y);
                        end
                    end
                end
                KICK_DONE: begin
                    req_ready <= 1'b1;
                    r_state   <= KICK_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    chk_valid <= 1'b0;
                    r_state   <= KICK_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clockwise_rotate_kicker.sv
// ============================================================================
// Module   : tb_clockwise_rotate_kicker
// Brief    : Randomized self-checking bench with an SRS offset-table model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clockwise_rotate_kicker;
    import clockwise_rotate_kicker_pkg::*;

    localparam int X_W = 5;
    localparam int Y_W = 6;

    // SRS offset tables indexed [rotation 0,R,2,L][test]; a kick is the
    // difference of source and target offsets, normalised to test 0.
    localparam int JX[4][5] = '{'{0, 0, 0, 0, 0}, '{0, 1, 1, 0, 1},
                                '{0, 0, 0, 0, 0}, '{0, -1, -1, 0, -1}};
    localparam int JY[4][5] = '{'{0, 0, 0, 0, 0}, '{0, 0, -1, 2, 2},
                                '{0, 0, 0, 0, 0}, '{0, 0, -1, 2, 2}};
    localparam int IX[4][5] = '{'{0, -1, 2, -1, 2}, '{-1, 0, 0, 0, 0},
                                '{-1, 1, -2, 1, -2}, '{0, 0, 0, 0, 0}};
    localparam int IY[4][5] = '{'{0, 0, 0, 0, 0}, '{0, 0, 0, 1, -2},
                                '{1, 1, 1, 0, 0}, '{1, 1, 1, -1, 2}};

    logic                  clk;
    logic                  reset_n;
    logic                  req_valid;
    logic                  req_ready;
    tetromino_idx_t        idx;
    logic signed [X_W-1:0] cur_x;
    logic signed [Y_W-1:0] cur_y;
    logic [1:0]            cur_rot;
    logic                  chk_valid;
    logic signed [X_W-1:0] chk_x;
    logic signed [Y_W-1:0] chk_y;
    logic [1:0]            chk_rot;
    logic                  chk_resp;
    logic                  chk_collide;
    logic                  res_valid;
    logic                  res_ok;
    logic signed [X_W-1:0] res_x;
    logic signed [Y_W-1:0] res_y;
    logic [1:0]            res_rot;

    int n_checks = 0;
    int n_pass   = 0;

    clockwise_rotate_kicker #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .idx         (idx),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .cur_rot     (cur_rot),
        .chk_valid   (chk_valid),
        .chk_x       (chk_x),
        .chk_y       (chk_y),
        .chk_rot     (chk_rot),
        .chk_resp    (chk_resp),
        .chk_collide (chk_collide),
        .res_valid   (res_valid),
        .res_ok      (res_ok),
        .res_x       (res_x),
        .res_y       (res_y),
        .res_rot     (res_rot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void ref_kick(input int pidx, input int rot, input int s,
                                     output int kx, output int ky);
        int to;
        to = (rot + 1) % 4;
        kx = 0;
        ky = 0;
        if (pidx == int'(TETROMINO_O_IDX) || s == 0) return;
        if (pidx == int'(TETROMINO_I_IDX)) begin
            kx = (IX[rot][s] - IX[to][s]) - (IX[rot][0] - IX[to][0]);
            ky = (IY[rot][s] - IY[to][s]) - (IY[rot][0] - IY[to][0]);
        end else begin
            kx = (JX[rot][s] - JX[to][s]) - (JX[rot][0] - JX[to][0]);
            ky = (JY[rot][s] - JY[to][s]) - (JY[rot][0] - JY[to][0]);
        end
    endfunction

    task automatic do_rotate(input int pidx, input int px, input int py, input int prot,
                             input logic [4:0] cmask, input int dly, input bit poke);
        int last, s, kx, ky, ex, ey, n, ok_exp, fx, fy, frot;
        last = (pidx == int'(TETROMINO_O_IDX)) ? 0 : 4;
        ok_exp = 0; fx = px; fy = py; frot = prot; ex = px; ey = py;
        @(negedge clk);
        check("req_ready_idle", int'(req_ready), 1);
        req_valid = 1'b1;
        idx       = 3'(pidx);
        cur_x     = X_W'(px);
        cur_y     = Y_W'(py);
        cur_rot   = 2'(prot);
        @(negedge clk);
        req_valid = 1'b0;
        cur_x     = X_W'($urandom);
        cur_y     = Y_W'($urandom);
        cur_rot   = 2'($urandom);
        check("req_ready_busy", int'(req_ready), 0);
        s = 0;
        forever begin
            n = 0;
            while (!chk_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("chk_valid", int'(chk_valid), 1);
            ref_kick(pidx, prot, s, kx, ky);
            ex = px + kx;
            ey = py + ky;
            check("chk_x", int'($signed(chk_x)), ex);
            check("chk_y", int'($signed(chk_y)), ey);
            check("chk_rot", int'(chk_rot), (prot + 1) % 4);
            for (int d = 0; d < dly; d++) begin
                req_valid = poke;
                cur_x     = X_W'($urandom_range(0, 7));
                @(negedge clk);
                req_valid = 1'b0;
                check("chk_hold_x", int'($signed(chk_x)), ex);
                check("chk_hold_y", int'($signed(chk_y)), ey);
                check("req_ready_wait", int'(req_ready), 0);
            end
            chk_resp    = 1'b1;
            chk_collide = cmask[s];
            @(negedge clk);
            chk_resp    = 1'b0;
            chk_collide = 1'b0;
            if (!cmask[s]) begin
                ok_exp = 1; fx = ex; fy = ey; frot = (prot + 1) % 4;
                break;
            end
            if (s == last) begin
                ok_exp = 0; fx = px; fy = py; frot = prot;
                break;
            end
            s++;
        end
        check("res_valid", int'(res_valid), 1);
        check("res_ok", int'(res_ok), ok_exp);
        check("res_x", int'($signed(res_x)), fx);
        check("res_y", int'($signed(res_y)), fy);
        check("res_rot", int'(res_rot), frot);
        check("chk_valid_off", int'(chk_valid), 0);
        @(negedge clk);
        check("res_valid_pulse", int'(res_valid), 0);
        check("req_ready_back", int'(req_ready), 1);
        check("res_x_hold", int'($signed(res_x)), fx);
        check("res_ok_hold", int'(res_ok), ok_exp);
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        idx         = '0;
        cur_x       = '0;
        cur_y       = '0;
        cur_rot     = '0;
        chk_resp    = 1'b0;
        chk_collide = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_chk_valid", int'(chk_valid), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_ok", int'(res_ok), 0);
        check("rst_res_x", int'($signed(res_x)), 0);
        check("rst_chk_x", int'($signed(chk_x)), 0);
        reset_n = 1'b1;

        do_rotate(int'(TETROMINO_T_IDX), 4, 10, 0, 5'b00000, 0, 1'b0);
        do_rotate(int'(TETROMINO_I_IDX), 4, 10, 0, 5'b00011, 0, 1'b0);
        do_rotate(int'(TETROMINO_J_IDX), 3, 5, 3, 5'b11111, 0, 1'b0);
        do_rotate(int'(TETROMINO_O_IDX), 6, 10, 0, 5'b11111, 0, 1'b0);
        do_rotate(int'(TETROMINO_S_IDX), 5, 12, 1, 5'b00001, 3, 1'b1);

        // Reset while a candidate is outstanding.
        @(negedge clk);
        req_valid = 1'b1;
        idx       = TETROMINO_T_IDX;
        cur_x     = 5'sd4;
        cur_y     = 6'sd10;
        cur_rot   = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_chk_valid", int'(chk_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_req_ready", int'(req_ready), 1);
        check("mid_rst_chk_valid", int'(chk_valid), 0);
        check("mid_rst_res_valid", int'(res_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_res_valid", int'(res_valid), 0);
        end
        do_rotate(int'(TETROMINO_Z_IDX), 7, 9, 2, 5'b00111, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            do_rotate($urandom_range(0, 6), $urandom_range(3, 12), $urandom_range(3, 28),
                      $urandom_range(0, 3), 5'($urandom), $urandom_range(0, 2),
                      1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
